instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_pc_next.sv | 28 ++
 rtl/instr_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared processor package: fetch FSM states and default fetch widths.
package instr_fetch_pkg;

  localparam int PC_W_DEF = 10;
  localparam int IW_DEF   = 9;

  localparam logic [IW_DEF-1:0] HALT_OP_DEF = '1;

  localparam logic [15:0] CYCLE_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next program-counter selection: sequential increment, PC-relative add
// or absolute branch target. Wraps naturally modulo 2^PC_W.
module pc_next
  import instr_fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic            branch_taken,
  input  logic            branch_abs,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] next_pc
);

  // The relative target is a two's-complement offset, so a plain
  // PC_W-bit add handles both forward and backward branches.
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (branch_taken) begin
      if (branch_abs) begin
        next_pc = branch_target;
      end else begin
        next_pc = pc + branch_target;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the ROM address, registers the returned
// word for decode, squashes the wrong-path word after a taken branch and
// stops when the halt opcode reaches the fetch register.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              PC_W    = PC_W_DEF,
  parameter int              IW      = IW_DEF,
  parameter logic [IW-1:0]   HALT_OP = IW'(HALT_OP_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            branch_abs,
  input  logic [PC_W-1:0] branch_target,
  input  logic [IW-1:0]   instr_in,
  output logic [PC_W-1:0] pc_out,
  output logic [IW-1:0]   instr_out,
  output logic            instr_valid,
  output logic [2:0]      imm_index,
  output logic            halted,
  output logic [15:0]     cycle_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] next_pc;

  pc_next #(
    .PC_W(PC_W)
  ) u_pc_next (
    .pc            (pc_out),
    .branch_taken  (branch_taken),
    .branch_abs    (branch_abs),
    .branch_target (branch_target),
    .next_pc       (next_pc)
  );

  // The immediate-table index is simply the low bits of the fetched word.
  assign imm_index = instr_out[2:0];

  // Fetch FSM, PC, fetch register and cycle counter. The halt check comes
  // first so that neither a stall nor a branch can keep a halt word alive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc_out      <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          instr_valid <= 1'b0;
          if (start) begin
            state       <= FETCH;
            pc_out      <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
          end
        end
        FETCH: begin
          if (instr_valid && (instr_out == HALT_OP)) begin
            state       <= HALT;
            halted      <= 1'b1;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            pc_out      <= next_pc;
            instr_out   <= instr_in;
            instr_valid <= !branch_taken;
            if (cycle_count != CYCLE_MAX) begin
              cycle_count <= cycle_count + 16'd1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
